// File: rtl/rv_decode_stage_if.sv
// ---------------------------------------------------------------------------
// rv_decode_stage_if
// Handshake and payload bundle between fetch, the decode stage and execute.
//   flush                      : discard everything buffered in the stage
//   in_valid/in_ready          : fetch -> decode handshake
//   in_pc, in_instr            : fetched PC and raw 32-bit instruction word
//   out_valid/out_ready        : decode -> execute handshake
//   out_*                      : registered, decoded control bundle
// Modports:
//   slave  : the decode stage itself
//   master : the environment driving it (fetch + execute side)
// Optional macro RV_DECODE_MEXT_EN adds out_is_mul (M extension).
// ---------------------------------------------------------------------------
interface rv_decode_stage_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [2:0]      out_funct3;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic            out_rd_we;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_alu_op;
   logic            out_is_cmp;
   logic            out_illegal;
`ifdef RV_DECODE_MEXT_EN
   logic            out_is_mul;
`endif

   modport slave (
      input  flush, in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_opcode, out_funct3,
             out_rs1, out_rs2, out_rd, out_rd_we, out_imm, out_alu_op,
`ifdef RV_DECODE_MEXT_EN
             out_is_mul,
`endif
             out_is_cmp, out_illegal
   );

   modport master (
      output flush, in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_opcode, out_funct3,
             out_rs1, out_rs2, out_rd, out_rd_we, out_imm, out_alu_op,
`ifdef RV_DECODE_MEXT_EN
             out_is_mul,
`endif
             out_is_cmp, out_illegal
   );
endinterface

// File: rtl/rv_decode_stage.sv
// ---------------------------------------------------------------------------
// rv_decode_stage
// RV32I decode stage sitting between fetch and execute. Each accepted
// instruction is decoded combinationally and registered into a 2-entry
// skid buffer (main + skid register), so in_ready can be a flop while the
// stage still sustains one instruction per cycle under backpressure.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : rv_decode_stage_if.slave (fetch handshake in, decoded bundle out)
// Parameters:
//   XLEN    : width of PC and immediates (32 or 64)
//   SHAMT_W : shift-amount width used for shift-immediate legality
// Optional macro RV_DECODE_MEXT_EN: OP with funct7=0000001 becomes legal
// and is flagged on out_is_mul.
// ---------------------------------------------------------------------------
module rv_decode_stage #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   rv_decode_stage_if.slave   bus
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_SRA = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            rd_we;
      logic [XLEN-1:0] imm;
      logic [2:0]      alu_op;
      logic            is_cmp;
      logic            illegal;
`ifdef RV_DECODE_MEXT_EN
      logic            is_mul;
`endif
   } bundle_t;

   // funct3 -> ALU op for OP/OP-IMM before funct7/instr[30] refinement.
   // slt/sltu are computed by the execute stage as a subtract.
   function automatic logic [2:0] base_alu(input logic [2:0] f3);
      logic [2:0] op;
      case (f3)
         3'b000:         op = ALU_ADD;
         3'b001:         op = ALU_SLL;
         3'b010, 3'b011: op = ALU_SUB;
         3'b100:         op = ALU_XOR;
         3'b101:         op = ALU_SRL;
         3'b110:         op = ALU_OR;
         default:        op = ALU_AND;
      endcase
      return op;
   endfunction

   logic [1:0] state_reg, state_next;
   logic       in_ready_reg;
   bundle_t    main_reg, main_next;
   bundle_t    skid_reg, skid_next;
   bundle_t    dec;
   logic [31:0] instr;
   logic [31:0] imm32;
   logic [11:0] shift_hi;
   logic       accept, drain;

   assign instr = bus.in_instr;

   // ---------------------------------------------------------------- decode
   always_comb begin
      dec        = '0;
      imm32      = '0;
      shift_hi   = '0;
      dec.pc     = bus.in_pc;
      dec.opcode = instr[6:0];
      dec.funct3 = instr[14:12];
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.rd     = instr[11:7];
      dec.alu_op = ALU_ADD;
      case (instr[6:0])
         OPC_LUI, OPC_AUIPC: imm32 = {instr[31:12], 12'b0};
         OPC_JAL: imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         OPC_JALR: begin
            imm32       = {{20{instr[31]}}, instr[31:20]};
            dec.illegal = (instr[14:12] != 3'b000);
         end
         OPC_BRANCH: begin
            imm32       = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            dec.illegal = (instr[14:13] == 2'b01);
         end
         OPC_LOAD: begin
            imm32       = {{20{instr[31]}}, instr[31:20]};
            dec.illegal = (instr[14:12] == 3'b011) || (instr[14:13] == 2'b11);
         end
         OPC_STORE: begin
            imm32       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            dec.illegal = (instr[14:12] > 3'b010);
         end
         OPC_OPIMM: begin
            imm32      = {{20{instr[31]}}, instr[31:20]};
            dec.alu_op = base_alu(instr[14:12]);
            dec.is_cmp = (instr[14:13] == 2'b01);
            if (instr[14:12] == 3'b101 && instr[30])
               dec.alu_op = ALU_SRA;
            // Bits above the shift amount must be zero; bit 30 is the
            // arithmetic-shift selector and is allowed for srai only.
            if (instr[13:12] == 2'b01) begin
               shift_hi = instr[31:20];
               if (instr[14])
                  shift_hi[10] = 1'b0;
               dec.illegal = ((shift_hi >> SHAMT_W) != 12'd0);
            end
         end
         OPC_OP: begin
            dec.alu_op = base_alu(instr[14:12]);
            dec.is_cmp = (instr[14:13] == 2'b01);
            if (instr[31:25] == 7'b0000000) begin
               dec.illegal = 1'b0;
            end else if (instr[31:25] == 7'b0100000) begin
               if (instr[14:12] == 3'b000)
                  dec.alu_op = ALU_SUB;
               else if (instr[14:12] == 3'b101)
                  dec.alu_op = ALU_SRA;
               else
                  dec.illegal = 1'b1;
`ifdef RV_DECODE_MEXT_EN
            end else if (instr[31:25] == 7'b0000001) begin
               dec.alu_op = ALU_ADD;
               dec.is_cmp = 1'b0;
               dec.is_mul = 1'b1;
`endif
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.imm        = {XLEN{imm32[31]}};
      dec.imm[31:0]  = imm32;
      dec.rd_we      = !dec.illegal && (dec.rd != 5'd0) &&
                       (instr[6:0] != OPC_BRANCH) && (instr[6:0] != OPC_STORE);
   end

   // ----------------------------------------------------------- skid buffer
   assign accept = bus.in_valid && in_ready_reg;
   assign drain  = (state_reg != EMPTY) && bus.out_ready;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      if (bus.flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: if (accept) begin
               state_next = ONE;
               main_next  = dec;
            end
            ONE: begin
               if (accept && !drain) begin
                  state_next = FULL;
                  skid_next  = dec;
               end else if (accept && drain) begin
                  main_next  = dec;
               end else if (drain) begin
                  state_next = EMPTY;
               end
            end
            FULL: if (drain) begin
               state_next = ONE;
               main_next  = skid_reg;
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= EMPTY;
         in_ready_reg <= 1'b1;
         main_reg     <= '0;
         skid_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= (state_next != FULL);
         main_reg     <= main_next;
         skid_reg     <= skid_next;
      end
   end

   assign bus.in_ready    = in_ready_reg;
   assign bus.out_valid   = (state_reg != EMPTY);
   assign bus.out_pc      = main_reg.pc;
   assign bus.out_opcode  = main_reg.opcode;
   assign bus.out_funct3  = main_reg.funct3;
   assign bus.out_rs1     = main_reg.rs1;
   assign bus.out_rs2     = main_reg.rs2;
   assign bus.out_rd      = main_reg.rd;
   assign bus.out_rd_we   = main_reg.rd_we;
   assign bus.out_imm     = main_reg.imm;
   assign bus.out_alu_op  = main_reg.alu_op;
   assign bus.out_is_cmp  = main_reg.is_cmp;
   assign bus.out_illegal = main_reg.illegal;
`ifdef RV_DECODE_MEXT_EN
   assign bus.out_is_mul  = main_reg.is_mul;
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
module tb_rv_decode_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rv_decode_stage_if #(.XLEN(32)) bus ();

   rv_decode_stage #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic [31:0] imm;
      logic [2:0]  alu_op;
      logic        is_cmp;
      logic        illegal;
`ifdef RV_DECODE_MEXT_EN
      logic        is_mul;
`endif
   } bundle_t;

   int checks = 0;
   int errors = 0;
   bundle_t exp_q[$];

   logic [6:0] legal_ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                 7'h03, 7'h23, 7'h13, 7'h33};
   // funct3 -> ALU code: add sll sub(slt) sub(sltu) xor srl or and
   logic [2:0] f3_alu [8] = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

`ifdef RV_DECODE_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif

   // Reference decoder written from the instruction-set rules with
   // integer arithmetic for the immediates.
   function automatic bundle_t model(input logic [31:0] pc, input logic [31:0] w);
      bundle_t b;
      int s;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      b = '0;
      s = int'($signed(w));
      op = w[6:0];
      f3 = w[14:12];
      f7 = w[31:25];
      b.pc = pc; b.opcode = op; b.funct3 = f3;
      b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
      b.alu_op = 3'd0;
      if (op == 7'h37 || op == 7'h17) begin
         b.imm = w & 32'hFFFFF000;
      end else if (op == 7'h6F) begin
         b.imm = 32'((s >>> 31) * (1 << 20) + int'(w[19:12]) * 4096 +
                     int'(w[20]) * 2048 + int'(w[30:21]) * 2);
      end else if (op == 7'h67) begin
         b.imm = 32'(s >>> 20);
         b.illegal = (f3 != 0);
      end else if (op == 7'h63) begin
         b.imm = 32'((s >>> 31) * 4096 + int'(w[7]) * 2048 +
                     int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
         b.illegal = (f3 == 2 || f3 == 3);
      end else if (op == 7'h03) begin
         b.imm = 32'(s >>> 20);
         b.illegal = (f3 == 3 || f3 == 6 || f3 == 7);
      end else if (op == 7'h23) begin
         b.imm = 32'((s >>> 25) * 32 + int'(w[11:7]));
         b.illegal = (f3 > 2);
      end else if (op == 7'h13) begin
         b.imm = 32'(s >>> 20);
         b.alu_op = f3_alu[f3];
         b.is_cmp = (f3 == 2 || f3 == 3);
         if (f3 == 5 && w[30]) b.alu_op = 3'd2;
         if (f3 == 1) b.illegal = (f7 != 0);
         if (f3 == 5) b.illegal = (f7 != 7'h00 && f7 != 7'h20);
      end else if (op == 7'h33) begin
         b.alu_op = f3_alu[f3];
         b.is_cmp = (f3 == 2 || f3 == 3);
         if (f7 == 7'h20) begin
            if (f3 == 0) b.alu_op = 3'd3;
            else if (f3 == 5) b.alu_op = 3'd2;
            else b.illegal = 1'b1;
         end else if (f7 == 7'h01 && MEXT) begin
            b.alu_op = 3'd0;
            b.is_cmp = 1'b0;
`ifdef RV_DECODE_MEXT_EN
            b.is_mul = 1'b1;
`endif
         end else if (f7 != 7'h00) begin
            b.illegal = 1'b1;
         end
      end else begin
         b.illegal = 1'b1;
      end
      b.rd_we = !b.illegal && b.rd != 0 && op != 7'h63 && op != 7'h23;
      return b;
   endfunction

   function automatic bundle_t dut_bundle();
      bundle_t b;
      b.pc = bus.out_pc; b.opcode = bus.out_opcode; b.funct3 = bus.out_funct3;
      b.rs1 = bus.out_rs1; b.rs2 = bus.out_rs2; b.rd = bus.out_rd;
      b.rd_we = bus.out_rd_we; b.imm = bus.out_imm; b.alu_op = bus.out_alu_op;
      b.is_cmp = bus.out_is_cmp; b.illegal = bus.out_illegal;
`ifdef RV_DECODE_MEXT_EN
      b.is_mul = bus.out_is_mul;
`endif
      return b;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int pick;
      w = $urandom();
      pick = int'($urandom_range(0, 9));
      if (pick < 9) w[6:0] = legal_ops[pick];
      if (w[6:0] == 7'h33) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
         endcase
      end else if (w[6:0] == 7'h13 && $urandom_range(0, 1) == 1) begin
         w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bundle(input string tag, input bundle_t obs, input bundle_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the scoreboard, then check after the edge.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] w,
                       input logic rdy, input logic fl, input string tag);
      logic acc, drn;
      bus.in_valid = v; bus.in_pc = pc; bus.in_instr = w;
      bus.out_ready = rdy; bus.flush = fl;
      acc = v && (exp_q.size() < 2) && !fl;
      drn = (exp_q.size() > 0) && rdy;
      if (fl) begin
         exp_q.delete();
      end else begin
         if (drn) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(model(pc, w));
      end
      @(posedge clk);
      #1;
      chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_q.size() < 2));
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk_bundle({tag, ".bundle"}, dut_bundle(), exp_q[0]);
      $display("step %s v=%0b pc=%08h instr=%08h rdy=%0b flush=%0b -> out_valid=%0b out_pc=%08h in_ready=%0b",
               tag, v, pc, w, rdy, fl, bus.out_valid, bus.out_pc, bus.in_ready);
   endtask

   initial begin
      logic [31:0] pc;
      bus.flush = 0; bus.in_valid = 0; bus.in_pc = 0; bus.in_instr = 0; bus.out_ready = 0;

      // Reset state
      #12;
      chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset.out_imm", 64'(bus.out_imm), 64'd0);
      chk("reset.out_pc", 64'(bus.out_pc), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single accept: addi x1,x0,-1
      step(1, 32'h1000, 32'hFFF00093, 1, 0, "addi");
      chk("addi.rd", 64'(bus.out_rd), 64'd1);
      chk("addi.rd_we", 64'(bus.out_rd_we), 64'd1);
      chk("addi.imm", 64'(bus.out_imm), 64'hFFFF_FFFF);
      chk("addi.alu_op", 64'(bus.out_alu_op), 64'd0);
      chk("addi.illegal", 64'(bus.out_illegal), 64'd0);

      // Immediates: beq then jal back-to-back
      step(1, 32'h1004, 32'hFE208EE3, 1, 0, "beq");
      chk("beq.imm", 64'(bus.out_imm), 64'hFFFF_FFFC);
      chk("beq.rd_we", 64'(bus.out_rd_we), 64'd0);
      chk("beq.rs1", 64'(bus.out_rs1), 64'd1);
      chk("beq.rs2", 64'(bus.out_rs2), 64'd2);
      step(1, 32'h1008, 32'h001000EF, 1, 0, "jal");
      chk("jal.imm", 64'(bus.out_imm), 64'h0000_0800);
      chk("jal.rd_we", 64'(bus.out_rd_we), 64'd1);
      step(0, 0, 0, 1, 0, "idle");

      // Backpressure: A, B accepted, C stalled; A held stable
      step(1, 32'h2000, 32'h00100113, 0, 0, "bpA");
      step(1, 32'h2004, 32'h00200193, 0, 0, "bpB");
      chk("bp.in_ready_low", 64'(bus.in_ready), 64'd0);
      step(1, 32'h2008, 32'h00300213, 0, 0, "bpC_stall");
      chk("bp.hold_A", 64'(bus.out_pc), 64'h2000);
      step(1, 32'h2008, 32'h00300213, 1, 0, "bp_drainA");
      chk("bp.B_next", 64'(bus.out_pc), 64'h2004);
      step(1, 32'h2008, 32'h00300213, 1, 0, "bp_acceptC");
      chk("bp.C_next", 64'(bus.out_pc), 64'h2008);
      step(0, 0, 0, 1, 0, "bp_drainC");

      // Illegal encodings
      step(1, 32'h3000, 32'h00003003, 1, 0, "ill_load");
      chk("ill_load.illegal", 64'(bus.out_illegal), 64'd1);
      chk("ill_load.rd_we", 64'(bus.out_rd_we), 64'd0);
      step(1, 32'h3004, 32'h40001033, 1, 0, "ill_f7");
      chk("ill_f7.illegal", 64'(bus.out_illegal), 64'd1);
      step(1, 32'h3008, 32'h02000033, 1, 0, "mext");
      chk("mext.illegal", 64'(bus.out_illegal), 64'(!MEXT));
`ifdef RV_DECODE_MEXT_EN
      chk("mext.is_mul", 64'(bus.out_is_mul), 64'd1);
`endif
      step(0, 0, 0, 1, 0, "idle");

      // Flush while FULL with a new instruction presented
      step(1, 32'h4000, 32'h00500293, 0, 0, "flX");
      step(1, 32'h4004, 32'h00600313, 0, 0, "flY");
      step(1, 32'h4008, 32'h00700393, 0, 1, "flush");
      chk("flush.out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush.in_ready", 64'(bus.in_ready), 64'd1);
      step(0, 0, 0, 1, 0, "post_flush");
      step(0, 0, 0, 1, 0, "post_flush");

      // Randomized traffic
      pc = 32'h8000;
      for (int c = 0; c < 2000; c++) begin
         step($urandom_range(0, 3) != 0, pc, rand_instr(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, "rand");
         pc += 4;
      end
      step(0, 0, 0, 1, 0, "drain");
      step(0, 0, 0, 1, 0, "drain");

      // Async reset while FULL
      step(1, 32'h5000, 32'h00100093, 0, 0, "arA");
      step(1, 32'h5004, 32'h00200093, 0, 0, "arB");
      bus.in_valid = 0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset.out_valid", 64'(bus.out_valid), 64'd0);
      chk("areset.out_pc", 64'(bus.out_pc), 64'd0);
      chk("areset.in_ready", 64'(bus.in_ready), 64'd1);
      chk("areset.rd_we", 64'(bus.out_rd_we), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 1, 0, "post_reset");
      step(1, 32'h6000, 32'hFFF00093, 1, 0, "post_reset_addi");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_decode_stage.md
Name:
rv_decode_stage

Overview:
- Parametrised RV32I decode stage between fetch and execute.
- Takes raw 32-bit instruction words, each with its PC, over a valid/ready handshake.
- Produces registered, fully decoded control bundles: register indices, sign-extended immediates for I/S/B/U/J, ALU op, write-enable and an illegal-instruction flag.
- A 2-entry skid buffer keeps in_ready registered, so full throughput holds under backpressure.

Parameters:
- XLEN, 32, datapath width (32 or 64); width of PC and immediate outputs, and of the sign extension.
- SHAMT_W, $clog2(XLEN), width of the shift-amount field checked in shift-immediate legality.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all buffered instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_pc  in  XLEN  PC of the instruction.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  XLEN  PC passed through.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_rd_we  out  1  writes rd; forced 0 when rd==0, for branch/store, or when illegal.
- out_imm  out  XLEN  sign-extended immediate for the format; 0 for R-type.
- out_alu_op  out  3  add=000 sll=001 sra=010 sub=011 xor=100 srl=101 or=110 and=111.
- out_is_cmp  out  1  slt/sltu (OP/OP-IMM funct3 010/011); out_alu_op=sub in that case.
- out_illegal  out  1  instruction not legal.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0 except in_ready=1; state EMPTY; payload registers 0.
- Decode is combinational on in_instr; the result is registered on acceptance. Latency: accepted in cycle N, out_valid in N+1.
- States:
  - EMPTY: main register empty.
  - ONE: main register full.
  - FULL: main and skid registers full.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept, no drain -> FULL.
  - ONE + drain, no accept -> EMPTY.
  - ONE + accept + drain -> ONE.
  - FULL + drain -> ONE; skid moves to main.
  - FULL never accepts.
- in_ready = (next state != FULL), registered. Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Ordering strictly FIFO. Out payload must hold stable while out_valid & !out_ready.
- flush has priority: next state EMPTY; a same-cycle accept is dropped; out_valid=0 and in_ready=1 the next cycle.
- Immediates:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended from the top bit to XLEN (U sign-extended from bit 31).
- ALU op:
  - OP: funct7 0100000 selects sub (f3=000) or sra (f3=101).
  - OP-IMM: instr[30] selects sra for f3=101.
  - LUI, AUIPC, JAL, JALR, load, store, branch -> add.
- Illegal when any of:
  - instr[1:0] != 11.
  - opcode not in {LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, OP-IMM, OP}.
  - JALR f3 != 000.
  - LOAD f3 in {011, 110, 111}.
  - STORE f3 > 010.
  - BR f3 in {010, 011}.
  - OP funct7 not in {0000000, 0100000}, or 0100000 with f3 not in {000, 101}.
  - OP-IMM shift with instr[31:SHAMT_W+20] not 0 (sra: instr[30] excepted).
- When illegal, out_rd_we=0; the other fields are as decoded.

Optional Feature:
- Macro: RV_DECODE_MEXT_EN.
- Defined:
  - OP with funct7=0000001 is legal (M extension).
  - Adds output out_is_mul (1 bit) = 1 for such instructions; out_alu_op=add.
- Undefined:
  - funct7=0000001 is illegal.
  - out_is_mul port absent.

Test Plan:
- Single accept: in_instr=0xFFF00093 (addi x1,x0,-1), PC=0x1000, out_ready=1 -> next cycle out_valid=1, out_rd=1, out_rd_we=1, out_imm=0xFFFFFFFF, out_alu_op=000, out_illegal=0.
- Immediates: 0xFE208EE3 (beq x1,x2,-4) -> out_imm=0xFFFFFFFC, out_rd_we=0, rs1=1, rs2=2. 0x001000EF (jal x1,2048) -> out_imm=0x00000800, out_rd_we=1.
- Backpressure: out_ready=0, push A, B, C back-to-back -> A and B accepted, in_ready=0 from the cycle after B. Then out_ready=1 -> A, B, C emerge in order, no loss or duplication; A is held stable while stalled.
- Illegal: 0x00003003 (load f3=011) -> out_illegal=1, out_rd_we=0. 0x40001033 (funct7=0100000, f3=001) -> out_illegal=1. 0x02000033 -> illegal without RV_DECODE_MEXT_EN; legal with out_is_mul=1 when it is defined.
- Flush: FULL state plus in_valid=1 and flush=1 -> next cycle out_valid=0, in_ready=1, and the flushed instruction never appears.
- Async reset: drop rst_n mid-cycle while in FULL -> outputs clear immediately, without waiting for a clock edge; in_ready=1 after release.
